// File: rtl/cache_pkg.sv
// cache_pkg: shared widths, FSM state encoding, request-type constants and the
// address-field view used by the cache controller and its helpers.
//   TAG_W/INDEX_W/OFFSET_W : word-address split {tag, index, offset}
//   WORD_W/BLOCK_W         : CPU word and cache line widths
//   MEM_ADDR_W             : block address width {tag, index}
package cache_pkg;

  localparam int TAG_W      = 24;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 2;
  localparam int WORD_W     = 32;
  localparam int BLOCK_W    = 128;
  localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;
  localparam int MEM_ADDR_W = TAG_W + INDEX_W;
  localparam int CNT_W      = 32;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    COMPARE,
    WB,
    FETCH,
    REFILL,
    DONE
  } cache_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  // Block address seen by main memory: the word offset is dropped.
  function automatic logic [MEM_ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [INDEX_W-1:0] index);
    return {tag, index};
  endfunction

endpackage

// File: rtl/cache_perf_counters.sv
// cache_perf_counters: three free-running 32-bit performance counters that wrap
// at 2^32. Each counter advances by one on a clock edge where its strobe is high.
//   clk, rst                     : clock, asynchronous active-high reset
//   hit_inc, miss_inc, wb_inc    : single-cycle increment strobes from the FSM
//   hit_cnt, miss_cnt, wb_cnt    : counter values
module cache_perf_counters
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             hit_inc,
  input  logic             miss_inc,
  input  logic             wb_inc,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic [CNT_W-1:0] wb_cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_inc)  hit_cnt  <= hit_cnt + 1'b1;
      if (miss_inc) miss_cnt <= miss_cnt + 1'b1;
      if (wb_inc)   wb_cnt   <= wb_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: sequencing FSM for a 64-line direct-mapped, write-back,
// write-allocate cache array. Accepts one CPU word request at a time, strobes
// the array for lookup / write-hit / refill, runs the dirty-victim writeback and
// block fetch with main memory, and keeps hit/miss/writeback counters.
//   CPU side    : cpu_valid/cpu_ready accept handshake, cpu_req_type, cpu_addr,
//                 cpu_wdata in; cpu_done pulse and cpu_rdata out
//   Array side  : c_tag/c_index/c_offset/c_req_type latched request, c_read_en,
//                 c_write_en, c_refill strobes, c_wdata; c_hit, c_dirty,
//                 c_victim_tag, c_dirty_block, c_rdata back from the array
//   Memory side : mem_req held until mem_ack, mem_we, mem_addr, mem_wdata out;
//                 mem_rdata, mem_ack in
//   Counters    : hit_cnt, miss_cnt, wb_cnt
// All outputs are registered.
module cache_controller
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic                  cpu_req_type,
  input  logic [ADDR_W-1:0]     cpu_addr,
  input  logic [WORD_W-1:0]     cpu_wdata,
  output logic                  cpu_done,
  output logic [WORD_W-1:0]     cpu_rdata,
  output logic [TAG_W-1:0]      c_tag,
  output logic [INDEX_W-1:0]    c_index,
  output logic [OFFSET_W-1:0]   c_offset,
  output logic                  c_req_type,
  output logic                  c_read_en,
  output logic                  c_write_en,
  output logic                  c_refill,
  output logic [BLOCK_W-1:0]    c_wdata,
  input  logic                  c_hit,
  input  logic                  c_dirty,
  input  logic [TAG_W-1:0]      c_victim_tag,
  input  logic [BLOCK_W-1:0]    c_dirty_block,
  input  logic [WORD_W-1:0]     c_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [BLOCK_W-1:0]    mem_wdata,
  input  logic [BLOCK_W-1:0]    mem_rdata,
  input  logic                  mem_ack,
  output logic [CNT_W-1:0]      hit_cnt,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [CNT_W-1:0]      wb_cnt
);

  cache_state_t      state, next_state;
  addr_fields_t      req_fields;
  logic [WORD_W-1:0] wdata_q;
  logic              refilled;
  logic              hit_inc, miss_inc, wb_inc;
  logic              accept, write_hit;

  assign req_fields = addr_fields_t'(cpu_addr);
  assign accept     = (state == IDLE) && cpu_valid;
  assign write_hit  = (state == COMPARE) && c_hit && (c_req_type == REQ_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // The hit strobe is suppressed on the re-lookup after a refill so that a
  // miss is never also counted as a hit.
  always_comb begin
    next_state = state;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    wb_inc     = 1'b0;
    case (state)
      IDLE:    if (cpu_valid) next_state = LOOKUP;
      LOOKUP:  next_state = COMPARE;
      COMPARE: begin
        if (c_hit) begin
          hit_inc    = !refilled;
          next_state = DONE;
        end else begin
          miss_inc   = 1'b1;
          next_state = c_dirty ? WB : FETCH;
        end
      end
      WB: begin
        if (mem_ack) begin
          wb_inc     = 1'b1;
          next_state = FETCH;
        end
      end
      FETCH:   if (mem_ack) next_state = REFILL;
      REFILL:  next_state = LOOKUP;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so each strobe is a clean register
  // aligned with the state it belongs to. mem_addr/mem_wdata double as the
  // victim capture registers and are only loaded on entry to WB or FETCH, which
  // keeps them stable while waiting for mem_ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ready  <= 1'b1;
      cpu_done   <= 1'b0;
      cpu_rdata  <= '0;
      c_tag      <= '0;
      c_index    <= '0;
      c_offset   <= '0;
      c_req_type <= REQ_READ;
      c_read_en  <= 1'b0;
      c_write_en <= 1'b0;
      c_refill   <= 1'b0;
      c_wdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wdata_q    <= '0;
      refilled   <= 1'b0;
    end else begin
      cpu_ready  <= (next_state == IDLE);
      cpu_done   <= (next_state == DONE);
      c_read_en  <= (next_state == LOOKUP);
      c_refill   <= (next_state == REFILL);
      c_write_en <= write_hit;
      mem_req    <= (next_state == WB) || (next_state == FETCH);
      mem_we     <= (next_state == WB);

      if (accept) begin
        c_tag      <= req_fields.tag;
        c_index    <= req_fields.index;
        c_offset   <= req_fields.offset;
        c_req_type <= cpu_req_type;
        wdata_q    <= cpu_wdata;
        refilled   <= 1'b0;
      end else if (state == REFILL) begin
        refilled <= 1'b1;
      end

      if ((state == COMPARE) && c_hit && (c_req_type == REQ_READ))
        cpu_rdata <= c_rdata;

      if ((state == COMPARE) && (next_state == WB)) begin
        mem_addr  <= block_addr(c_victim_tag, c_index);
        mem_wdata <= c_dirty_block;
      end else if ((next_state == FETCH) && (state != FETCH)) begin
        mem_addr <= block_addr(c_tag, c_index);
      end

      if (next_state == REFILL)
        c_wdata <= mem_rdata;
      else if (write_hit)
        c_wdata <= {{(BLOCK_W-WORD_W){1'b0}}, wdata_q};
      else
        c_wdata <= '0;
    end
  end

  cache_perf_counters u_counters (
    .clk      (clk),
    .rst      (rst),
    .hit_inc  (hit_inc),
    .miss_inc (miss_inc),
    .wb_inc   (wb_inc),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );

endmodule
